l2_mshr_alloc: RTL and testbench

MSHR allocator and lookup unit for the Spandex L2. It hands out free MSHR indices to the request/fwd handlers and accepts deallocation when transactions retire. It answers same-line and same-set hit queries used for set-conflict decisions. It raises fwd_stall_ended when the MSHR entry a stalled forward waits on is freed.

---
 rtl/l2_mshr_alloc_pkg.sv | 13 +
 rtl/l2_mshr_alloc_prio_enc.sv | 19 +
 rtl/l2_mshr_alloc.sv | 73 +++++++
 tb/tb_l2_mshr_alloc.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/l2_mshr_alloc_pkg.sv
// l2_mshr_alloc_pkg: shared constants and types for the Spandex L2 MSHR allocator.
package l2_mshr_alloc_pkg;
  localparam int N_MSHR = 8;
  localparam int MSHR_BITS = 3;
  localparam int LINE_ADDR_BITS = 26;
  localparam int L2_SET_BITS = 9;
  typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;
  typedef logic [MSHR_BITS-1:0] mshr_idx_t;
  typedef logic [MSHR_BITS:0] mshr_cnt_t;
  function automatic logic [L2_SET_BITS-1:0] set_of(input line_addr_t a);
    return a[L2_SET_BITS-1:0];
  endfunction
endpackage

// File: rtl/l2_mshr_alloc_prio_enc.sv
// l2_mshr_prio_enc: finds the lowest zero bit of vec; idx is 0 when none is found.
module l2_mshr_prio_enc #(
  parameter int W = 8,
  parameter int IW = 3
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          found
);
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--)
      if (!vec[i]) begin
        idx = IW'(i);
        found = 1'b1;
      end
  end
endmodule

// File: rtl/l2_mshr_alloc.sv
// l2_mshr_alloc: MSHR allocator/lookup for the Spandex L2.
// Define L2_MSHR_DEALLOC_CHECK_EN to build the sticky dealloc_err checker.
module l2_mshr_alloc
  import l2_mshr_alloc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       alloc_req,
  input  line_addr_t alloc_addr,
  output logic       alloc_gnt,
  output mshr_idx_t  alloc_idx,
  output logic       full,
  input  logic       dealloc_valid,
  input  mshr_idx_t  dealloc_idx,
  input  line_addr_t lookup_addr,
  output logic       lookup_line_hit,
  output logic       lookup_set_hit,
  output mshr_idx_t  lookup_idx,
  input  logic       fwd_stall,
  input  mshr_idx_t  fwd_stall_entry,
  input  logic       clr_fwd_stall_ended,
  output logic       fwd_stall_ended,
  output mshr_cnt_t  free_cnt,
  output logic       dealloc_err
);
  logic [N_MSHR-1:0] valid, line_hv, set_hv;
  line_addr_t addr [N_MSHR];
  logic free_found, dealloc_ok;
  always_comb begin
    line_hv = '0;
    set_hv = '0;
    for (int i = 0; i < N_MSHR; i++) begin
      line_hv[i] = valid[i] && addr[i] == lookup_addr;
      set_hv[i] = valid[i] && set_of(addr[i]) == set_of(lookup_addr);
    end
  end
  l2_mshr_prio_enc #(.W(N_MSHR), .IW(MSHR_BITS)) u_free_enc (
    .vec(valid), .idx(alloc_idx), .found(free_found)
  );
  // Lowest line hit is the lowest zero of the inverted hit vector.
  l2_mshr_prio_enc #(.W(N_MSHR), .IW(MSHR_BITS)) u_hit_enc (
    .vec(~line_hv), .idx(lookup_idx), .found(lookup_line_hit)
  );
  assign lookup_set_hit = |set_hv;
  assign full = free_cnt == '0;
  assign alloc_gnt = alloc_req && !full && free_found;
  assign dealloc_ok = dealloc_valid && valid[dealloc_idx];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      for (int i = 0; i < N_MSHR; i++) addr[i] <= '0;
      free_cnt <= mshr_cnt_t'(N_MSHR);
      fwd_stall_ended <= 1'b0;
    end else begin
      if (alloc_gnt) begin
        valid[alloc_idx] <= 1'b1;
        addr[alloc_idx] <= alloc_addr;
      end
      if (dealloc_ok) valid[dealloc_idx] <= 1'b0;
      free_cnt <= free_cnt + mshr_cnt_t'(dealloc_ok) - mshr_cnt_t'(alloc_gnt);
      fwd_stall_ended <= clr_fwd_stall_ended ? 1'b0 :
                         (dealloc_ok && fwd_stall && dealloc_idx == fwd_stall_entry) ? 1'b1 : fwd_stall_ended;
    end
  end
`ifdef L2_MSHR_DEALLOC_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dealloc_err <= 1'b0;
    else dealloc_err <= dealloc_err || (dealloc_valid && !valid[dealloc_idx]) || (alloc_req && full);
  end
`else
  assign dealloc_err = 1'b0;
`endif
endmodule

// File: tb/tb_l2_mshr_alloc.sv
// tb_l2_mshr_alloc: directed and random checks of l2_mshr_alloc against a behavioural model.
module tb_l2_mshr_alloc;
  import l2_mshr_alloc_pkg::*;
  logic clk = 0, rst = 0;
  logic alloc_req = 0, dealloc_valid = 0, fwd_stall = 0, clr_fwd_stall_ended = 0;
  line_addr_t alloc_addr = '0, lookup_addr = '0;
  mshr_idx_t dealloc_idx = '0, fwd_stall_entry = '0;
  logic alloc_gnt, full, lookup_line_hit, lookup_set_hit, fwd_stall_ended, dealloc_err;
  mshr_idx_t alloc_idx, lookup_idx;
  mshr_cnt_t free_cnt;
  int tests = 0, fails = 0;
  bit m_valid [N_MSHR];
  int m_addr [N_MSHR];
  bit m_fse, m_err;

  always #5 clk = ~clk;

  l2_mshr_alloc dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_addr(alloc_addr),
    .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx), .full(full),
    .dealloc_valid(dealloc_valid), .dealloc_idx(dealloc_idx),
    .lookup_addr(lookup_addr), .lookup_line_hit(lookup_line_hit),
    .lookup_set_hit(lookup_set_hit), .lookup_idx(lookup_idx),
    .fwd_stall(fwd_stall), .fwd_stall_entry(fwd_stall_entry),
    .clr_fwd_stall_ended(clr_fwd_stall_ended), .fwd_stall_ended(fwd_stall_ended),
    .free_cnt(free_cnt), .dealloc_err(dealloc_err)
  );

  function automatic int m_free();
    int n = 0;
    for (int i = 0; i < N_MSHR; i++) if (!m_valid[i]) n++;
    return n;
  endfunction

  function automatic int m_lowest_free();
    for (int i = 0; i < N_MSHR; i++) if (!m_valid[i]) return i;
    return 0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_MSHR; i++) begin
        m_valid[i] = 0;
        m_addr[i] = 0;
      end
      m_fse = 0;
      m_err = 0;
    end else begin
      int lf, di;
      bit gnt, ok;
      lf = m_lowest_free();
      di = int'(dealloc_idx);
      gnt = alloc_req && m_free() > 0;
      ok = dealloc_valid && m_valid[di];
`ifdef L2_MSHR_DEALLOC_CHECK_EN
      if ((dealloc_valid && !m_valid[di]) || (alloc_req && m_free() == 0)) m_err = 1;
`endif
      if (clr_fwd_stall_ended) m_fse = 0;
      else if (ok && fwd_stall && di == int'(fwd_stall_entry)) m_fse = 1;
      if (gnt) begin
        m_valid[lf] = 1;
        m_addr[lf] = int'(alloc_addr);
      end
      if (ok) m_valid[di] = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    int n, hidx;
    bit lh, sh;
    n = m_free();
    lh = 0;
    sh = 0;
    hidx = 0;
    for (int i = 0; i < N_MSHR; i++)
      if (m_valid[i]) begin
        if (!lh && m_addr[i] == int'(lookup_addr)) begin
          lh = 1;
          hidx = i;
        end
        if ((m_addr[i] % 512) == (int'(lookup_addr) % 512)) sh = 1;
      end
    chk("full", full, n == 0);
    chk("alloc_gnt", alloc_gnt, alloc_req && n != 0);
    if (n != 0) chk("alloc_idx", alloc_idx, m_lowest_free());
    chk("free_cnt", free_cnt, n);
    chk("line_hit", lookup_line_hit, lh);
    chk("set_hit", lookup_set_hit, sh);
    chk("lookup_idx", lookup_idx, hidx);
    chk("fwd_stall_ended", fwd_stall_ended, m_fse);
    chk("dealloc_err", dealloc_err, m_err);
  endtask

  task automatic drive(input bit ar, input int aa, input bit dv, input int di,
                       input int la, input bit fs, input int fe, input bit clr);
    @(negedge clk);
    alloc_req = ar;
    alloc_addr = line_addr_t'(aa);
    dealloc_valid = dv;
    dealloc_idx = mshr_idx_t'(di);
    lookup_addr = line_addr_t'(la);
    fwd_stall = fs;
    fwd_stall_entry = mshr_idx_t'(fe);
    clr_fwd_stall_ended = clr;
    #1 compare();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int rnd_addr();
    return int'($urandom_range(0, 3)) * 512 * 128 + int'($urandom_range(0, 1)) * 512 + int'($urandom_range(0, 7));
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    #1 compare();
    chk("reset_free_cnt", free_cnt, 8);
    chk("reset_full", full, 0);
    rst = 1;
    for (int i = 0; i < 8; i++) begin
      drive(1, 'h10 + i, 0, 0, 0, 0, 0, 0);
      chk("fill_idx", alloc_idx, i);
      chk("fill_cnt", free_cnt, 8 - i);
    end
    drive(1, 'h18, 0, 0, 0, 0, 0, 0);
    chk("ninth_gnt", alloc_gnt, 0);
    chk("ninth_full", full, 1);
    chk("ninth_cnt", free_cnt, 0);
    drive(0, 0, 1, 3, 0, 0, 0, 0);
    drive(1, 'h40, 0, 0, 0, 0, 0, 0);
    chk("refill_idx", alloc_idx, 3);
    chk("refill_cnt", free_cnt, 1);
    idle();
    chk("refill_cnt_after", free_cnt, 0);
    foreach (m_valid[k]) if (k != 0 && k != 5) drive(0, 0, 1, k, 0, 0, 0, 0);
    drive(1, 'h50, 1, 0, 0, 0, 0, 0);
    chk("same_cycle_idx", alloc_idx, 1);
    chk("same_cycle_cnt_before", free_cnt, 6);
    idle();
    chk("same_cycle_cnt_after", free_cnt, 6);
    drive(1, 'h0, 0, 0, 0, 0, 0, 0);
    drive(1, 'h10023, 0, 0, 0, 0, 0, 0);
    chk("lookup_alloc_idx", alloc_idx, 2);
    drive(0, 0, 0, 0, 'h20023, 0, 0, 0);
    chk("set_only_set", lookup_set_hit, 1);
    chk("set_only_line", lookup_line_hit, 0);
    drive(0, 0, 0, 0, 'h10023, 0, 0, 0);
    chk("line_hit", lookup_line_hit, 1);
    chk("line_idx", lookup_idx, 2);
    drive(1, 'h60, 0, 0, 0, 0, 0, 0);
    drive(1, 'h61, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 5, 0, 1, 4, 0);
    idle();
    chk("fse_other", fwd_stall_ended, 0);
    drive(0, 0, 1, 4, 0, 1, 4, 0);
    idle();
    chk("fse_set", fwd_stall_ended, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk("fse_hold", fwd_stall_ended, 1);
    idle();
    chk("fse_clr", fwd_stall_ended, 0);
    drive(0, 0, 1, 6, 0, 0, 0, 0);
    idle();
    chk("bad_dealloc_cnt", free_cnt, 4);
`ifdef L2_MSHR_DEALLOC_CHECK_EN
    chk("bad_dealloc_err", dealloc_err, 1);
`else
    chk("bad_dealloc_err", dealloc_err, 0);
`endif
    for (int i = 0; i < 3000; i++) begin
      int la;
      if (i == 1500) begin
        @(negedge clk);
        rst = 0;
        #1 compare();
        chk("mid_reset_cnt", free_cnt, 8);
        @(negedge clk);
        rst = 1;
      end
      la = ($urandom_range(0, 1) == 1) ? m_addr[$urandom_range(0, N_MSHR - 1)] : rnd_addr();
      drive($urandom_range(0, 1), rnd_addr(), $urandom_range(0, 9) < 4, $urandom_range(0, 7),
            la, $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 9) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
